// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_pkg
// Description : Opcode constants, FSM state encoding and small decode helpers
//               shared by the hazard stall unit and the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Instructions whose rt field is a source operand (not a destination).
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == C_OP_RTYPE) || (op == C_OP_BEQ) ||
           (op == C_OP_BNE)   || (op == C_OP_SW);
  endfunction

  // Conditional branches that must wait for EX to settle the outcome.
  function automatic logic op_is_branch(input logic [5:0] op);
    return (op == C_OP_BEQ) || (op == C_OP_BNE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_if
// Description : Pipeline-side signal bundle of the hazard stall unit. The
//               master is the pipeline (drives ID/EX state), the slave is the
//               hazard unit (drives stall/flush/enable controls).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_inst;
  logic             ex_memr;
  logic [4:0]       ex_rt;
  logic             br_resolved;
  logic             undef_inst;
  logic             pipe_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_inst, ex_memr, ex_rt, br_resolved, undef_inst,
    input  pipe_stall, pc_write, ifid_write, ifid_flush, halted, stall_cnt
  );

  modport slave (
    input  id_inst, ex_memr, ex_rt, br_resolved, undef_inst,
    output pipe_stall, pc_write, ifid_write, ifid_flush, halted, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit_load_use.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detection between the load in
//               ID/EX and the instruction in IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import hazard_stall_unit_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       ex_memr_i,
  input  logic [4:0] ex_rt_i,
  output logic       hazard_o
);

  logic w_rs_match;
  logic w_rt_match;

  // $0 is never a real dependency; rt only matters when the opcode reads it.
  assign w_rs_match = (ex_rt_i == rs_i);
  assign w_rt_match = (ex_rt_i == rt_i) && op_reads_rt(opcode_i);
  assign hazard_o   = ex_memr_i && (ex_rt_i != 5'd0) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline hazard controller. Stalls one cycle on load-use,
//               freezes fetch while a branch resolves (with a timeout into
//               HALT), flushes on jumps, halts on undefined instructions and
//               counts stall cycles with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int BR_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_unit_if.slave  bus
);

  localparam int                WAIT_W       = $clog2(BR_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LIMIT = WAIT_W'(BR_TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              halted_q;

  logic [5:0]        w_opcode;
  logic              w_load_use;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_pipe_stall;
  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_ifid_flush;
  logic              w_unused_imm;

  assign w_opcode     = bus.id_inst[31:26];
  assign w_wait_inc   = wait_cnt_q + WAIT_W'(1);
  // Immediate/rd/funct bits play no part in hazard decisions.
  assign w_unused_imm = ^bus.id_inst[15:0];

  load_use_detect u_load_use (
    .opcode_i  (w_opcode),
    .rs_i      (bus.id_inst[25:21]),
    .rt_i      (bus.id_inst[20:16]),
    .ex_memr_i (bus.ex_memr),
    .ex_rt_i   (bus.ex_rt),
    .hazard_o  (w_load_use)
  );

  // Mealy control outputs and next-state selection; reset forces free-run.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    w_pipe_stall = 1'b0;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.undef_inst) begin
            state_d      = HALT;
            w_pipe_stall = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
          end else if (w_load_use) begin
            w_pipe_stall = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
          end else if (op_is_branch(w_opcode)) begin
            state_d      = BR_WAIT;
            wait_cnt_d   = '0;
            w_pc_write   = 1'b0;
            w_ifid_flush = 1'b1;
          end else if (w_opcode == C_OP_J) begin
            w_ifid_flush = 1'b1;
          end
        end
        BR_WAIT: begin
          w_pipe_stall = 1'b1;
          wait_cnt_d   = w_wait_inc;
          if (bus.br_resolved) begin
            w_ifid_flush = 1'b1;
            state_d      = IDLE;
          end else begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            if (w_wait_inc == C_WAIT_LIMIT) begin
              state_d = HALT;
            end
          end
        end
        HALT: begin
          w_pipe_stall = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, branch wait counter, halted flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= (state_d == HALT);
      if (w_pipe_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pipe_stall = w_pipe_stall;
  assign bus.pc_write   = w_pc_write;
  assign bus.ifid_write = w_ifid_write;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.halted     = halted_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed self-checking bench for hazard_stall_unit. Control
//               outputs are compared as {pipe_stall,pc_write,ifid_write,
//               ifid_flush}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;

  localparam logic [3:0] C_RUN   = 4'b0110;
  localparam logic [3:0] C_STALL = 4'b1000;
  localparam logic [3:0] C_BRENT = 4'b0011;
  localparam logic [3:0] C_BRRES = 4'b1111;
  localparam logic [3:0] C_JUMP  = 4'b0111;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = {6'b000000, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADDI = {6'b001000, 5'd1, 5'd7, 16'd4};
  localparam logic [31:0] I_SW   = {6'b101011, 5'd1, 5'd7, 16'd0};
  localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd7, 16'd0};
  localparam logic [31:0] I_BEQ  = {6'b000100, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] I_BNE  = {6'b000101, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] I_J    = {6'b000010, 26'd100};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.CNT_W(CNT_W), .BR_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] ctl();
    return {bus.pipe_stall, bus.pc_write, bus.ifid_write, bus.ifid_flush};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic memr, input logic [4:0] rt,
                       input logic br, input logic undef);
    bus.id_inst     = inst;
    bus.ex_memr     = memr;
    bus.ex_rt       = rt;
    bus.br_resolved = br;
    bus.undef_inst  = undef;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(I_ADD, 1'b1, 5'd5, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL rst_ctl got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    tick();
    n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); else n_pass++;
    n_total++; if (bus.halted !== 1'b0) $display("FAIL rst_halted got=%b exp=0", bus.halted); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (ctl() !== C_STALL) $display("FAIL rst_release got=%b exp=%b", ctl(), C_STALL); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(I_ADD, 1'b1, 5'd5, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL lu_rs got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    drive(I_ADD, 1'b0, 5'd5, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL lu_release got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd1) $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); else n_pass++;
    drive(I_ADD, 1'b1, 5'd2, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL lu_rt_rtype got=%b exp=%b", ctl(), C_STALL); else n_pass++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive(I_NOP, 1'b1, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL lu_r0 got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    drive(I_ADDI, 1'b1, 5'd7, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL lu_addi_rt got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    drive(I_ADDI, 1'b1, 5'd1, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL lu_addi_rs got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    drive(I_SW, 1'b1, 5'd7, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL lu_sw_rt got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    drive(I_LW, 1'b1, 5'd7, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL lu_lw_rt got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    drive(I_ADD, 1'b0, 5'd5, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL lu_nomemr got=%b exp=%b", ctl(), C_RUN); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    drive(I_BEQ, 1'b1, 5'd2, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL prio_lu_br got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL prio_stay_idle got=%b exp=%b", ctl(), C_RUN); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    drive(I_BEQ, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_BRENT) $display("FAIL br_enter got=%b exp=%b", ctl(), C_BRENT); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL br_wait1 got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    n_total++; if (ctl() !== C_STALL) $display("FAIL br_wait2 got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    n_total++; if (ctl() !== C_BRRES) $display("FAIL br_resolve got=%b exp=%b", ctl(), C_BRRES); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL br_back_idle got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd3) $display("FAIL br_cnt got=%0d exp=3", bus.stall_cnt); else n_pass++;
    // bne resolved on the first wait cycle
    drive(I_BNE, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_BRENT) $display("FAIL bne_enter got=%b exp=%b", ctl(), C_BRENT); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    n_total++; if (ctl() !== C_BRRES) $display("FAIL bne_resolve got=%b exp=%b", ctl(), C_BRRES); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (bus.stall_cnt !== 4'd4) $display("FAIL bne_cnt got=%0d exp=4", bus.stall_cnt); else n_pass++;
  endtask

  task automatic test_jump();
    do_reset();
    drive(I_J, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_JUMP) $display("FAIL jump got=%b exp=%b", ctl(), C_JUMP); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL jump_after got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if (ctl() !== C_RUN) $display("FAIL br_ignored_idle got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL jump_cnt got=%0d exp=0", bus.stall_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    drive(I_BEQ, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      n_total++;
      if ({ctl(), bus.halted} !== {C_STALL, 1'b0})
        $display("FAIL to_wait%0d got=%b/%b exp=%b/0", k, ctl(), bus.halted, C_STALL);
      else n_pass++;
      tick();
    end
    n_total++; if (bus.halted !== 1'b1) $display("FAIL to_halted got=%b exp=1", bus.halted); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd8) $display("FAIL to_cnt got=%0d exp=8", bus.stall_cnt); else n_pass++;
    drive(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    n_total++; if (ctl() !== C_STALL) $display("FAIL halt_ctl got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if ({ctl(), bus.halted} !== {C_STALL, 1'b1}) $display("FAIL halt_br_ignored got=%b/%b exp=%b/1", ctl(), bus.halted, C_STALL); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (ctl() !== C_RUN) $display("FAIL halt_rst_ctl got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if ({ctl(), bus.halted, bus.stall_cnt} !== {C_RUN, 1'b0, 4'd0})
      $display("FAIL halt_rst_idle got=%b/%b/%0d exp=%b/0/0", ctl(), bus.halted, bus.stall_cnt, C_RUN);
    else n_pass++;
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    drive(I_BEQ, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    n_total++; if (ctl() !== C_RUN) $display("FAIL midwait_rst_ctl got=%b exp=%b", ctl(), C_RUN); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if ({ctl(), bus.stall_cnt} !== {C_RUN, 4'd0})
      $display("FAIL midwait_idle got=%b/%0d exp=%b/0", ctl(), bus.stall_cnt, C_RUN);
    else n_pass++;
  endtask

  task automatic test_undef();
    do_reset();
    drive(I_ADD, 1'b1, 5'd5, 1'b0, 1'b1);
    n_total++; if ({ctl(), bus.halted} !== {C_STALL, 1'b0}) $display("FAIL undef_lu got=%b/%b exp=%b/0", ctl(), bus.halted, C_STALL); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    n_total++; if ({ctl(), bus.halted} !== {C_STALL, 1'b1}) $display("FAIL undef_halt got=%b/%b exp=%b/1", ctl(), bus.halted, C_STALL); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd1) $display("FAIL undef_cnt1 got=%0d exp=1", bus.stall_cnt); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.stall_cnt !== 4'd3) $display("FAIL undef_cnt3 got=%0d exp=3", bus.stall_cnt); else n_pass++;
    repeat (20) tick();
    n_total++; if (bus.stall_cnt !== 4'hF) $display("FAIL cnt_saturate got=%0d exp=15", bus.stall_cnt); else n_pass++;
    // undefined instruction outranks a branch in the same cycle
    do_reset();
    drive(I_BEQ, 1'b0, 5'd0, 1'b0, 1'b1);
    n_total++; if (ctl() !== C_STALL) $display("FAIL undef_br got=%b exp=%b", ctl(), C_STALL); else n_pass++;
    tick();
    drive(I_NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    n_total++; if ({ctl(), bus.halted} !== {C_STALL, 1'b1}) $display("FAIL undef_br_halt got=%b/%b exp=%b/1", ctl(), bus.halted, C_STALL); else n_pass++;
  endtask

  initial begin
    drive(I_NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_priority();
    test_branch();
    test_jump();
    test_timeout();
    test_rst_mid_wait();
    test_undef();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
